alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: WIDTH, default 16, datapath/register width; all data ports below are WIDTH bits.
REQ-002 Clock/reset: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 instr_valid  in  1  instruction offered.
REQ-006 instr  in  16  instruction: [15:12] op, [11:8] Rdest, [7:4] opext, [3:0] Rsrc; imm8 = [7:0].
REQ-007 instr_ready  out  1  sequencer can accept an instruction.
REQ-008 rf_raddr_a / rf_raddr_b  out  4 each  register-file read addresses (Rsrc / Rdest).
REQ-009 rf_rdata_a / rf_rdata_b  in  WIDTH each  read data, valid one cycle after address (synchronous read).
REQ-010 alu_src / alu_dst  out  WIDTH each  ALU sourceData / destData.
REQ-011 alu_op  out  8  ALU operationControl = {op, opext}.
REQ-012 alu_en  out  1  ALU enable.
REQ-013 alu_result  in  WIDTH  ALU result.
REQ-014 alu_flags  in  5  {carry, low, overflow, zero, negative} from ALU.
REQ-015 rf_we  out  1, rf_waddr  out  4, rf_wdata  out  WIDTH  register write port.
REQ-016 psr  out  5  status register, same bit order as alu_flags.
REQ-017 done  out  1  one-cycle pulse at end of every accepted instruction.
REQ-018 illegal  out  1  one-cycle pulse with done for an undecodable instruction.

Function
REQ-019 FSM states IDLE -> READ -> EXEC -> WB -> IDLE, one cycle each except IDLE.
REQ-020 IDLE: instr_ready=1; on instr_valid, instr latched into IR, go READ; instr_ready=0 in all other states.
REQ-021 READ: rf_raddr_a=IR[3:0], rf_raddr_b=IR[11:8]; decode/legality computed.
REQ-022 EXEC: alu_en=1, alu_op={IR[15:12],IR[7:4]}, alu_dst=rf_rdata_b, alu_src per REQ-023; alu_result and alu_flags captured into internal registers at end of cycle; alu_en=0 in all other states.
REQ-023 Source select: op 0000 -> rf_rdata_a; op 1000 with opext 0100/0110 -> rf_rdata_a, other shift opexts -> zero-extended IR[3:0]; ops 0101 (ADDI), 1001 (SUBI), 1011 (CMPI) -> sign-extended IR[7:0]; ops 0110, 0001, 0010, 0011, 1101, 1111 -> zero-extended IR[7:0].
REQ-024 Legal set: op 0000 with opext in {0101,0110,0111,1110,1001,1010,1011,0001,0010,0011,1101}; op 1000 with opext in {0000,0001,0010,0011,0100,0110}; ops {0101,0110,1001,1011,0001,0010,0011,1101,1111}; everything else illegal.
REQ-025 WB: done=1; legal: psr <= captured flags; rf_we=1, rf_waddr=IR[11:8], rf_wdata=captured result, except CMP (0000/1011) and CMPI (1011) which leave rf_we=0.
REQ-026 WB illegal: rf_we=0, psr unchanged, illegal=1.
REQ-027 Latency fixed: instruction accepted at edge N -> WB (done) during cycle N+3; throughput one per 4 cycles; illegal instructions take the same path/latency.
REQ-028 instr_valid while not IDLE is ignored (no queueing); held valid is accepted in the IDLE cycle following WB.
REQ-029 rf_we, done, illegal are never asserted outside WB.
REQ-030 Unused outputs (addresses, alu_src/dst, rf_waddr/wdata) SHALL be driven 0 outside their active states; no latches.

Reset
REQ-031 reset at any edge: state IDLE, IR=0, captured result/flags=0, psr=0; next cycle instr_ready=1, rf_we=0, done=0, illegal=0, alu_en=0.
REQ-032 reset mid-instruction aborts it: no register write, no psr update, no done.
REQ-033 reset and instr_valid in the same cycle: instruction not accepted.

Verification
REQ-034 R1=0x0003, R2=0x0005, instr 0x0251 (ADD) -> WB at accept+3: rf_we=1, rf_waddr=2, rf_wdata=0x0008, done=1.
REQ-035 R3=0x0001, instr 0x53FF (ADDI -1) -> alu_src=0xFFFF in EXEC; rf_wdata=0x0000, psr[4] (carry)=1.
REQ-036 R4=0x0003, instr 0xB405 (CMPI #5) -> rf_we=0; psr low=1, negative=1.
REQ-037 instr 0x4000 -> done=1, illegal=1 at accept+3; rf_we=0; psr unchanged.
REQ-038 reset asserted during EXEC of 0x0251 -> no rf_we, no done; next cycle IDLE, instr_ready=1, psr=0.
REQ-039 instr_valid held high with two instructions back-to-back -> second accepted exactly one cycle after first done; done pulses 4 cycles apart.

Source files
------------

// File: rtl/alu_sequencer.sv
// Four-cycle IDLE->READ->EXEC->WB sequencer driving a register file and an external ALU; done in cycle accept+3.
// One instruction in flight: instr_ready only in IDLE, instr_valid ignored elsewhere (no queueing).
module alu_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [15:0]      instr,
  output logic             instr_ready,
  output logic [3:0]       rf_raddr_a,
  output logic [3:0]       rf_raddr_b,
  input  logic [WIDTH-1:0] rf_rdata_a,
  input  logic [WIDTH-1:0] rf_rdata_b,
  output logic [WIDTH-1:0] alu_src,
  output logic [WIDTH-1:0] alu_dst,
  output logic [7:0]       alu_op,
  output logic             alu_en,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [4:0]       alu_flags,
  output logic             rf_we,
  output logic [3:0]       rf_waddr,
  output logic [WIDTH-1:0] rf_wdata,
  output logic [4:0]       psr,
  output logic             done,
  output logic             illegal
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t           state, state_nxt;
  logic [15:0]      ir;
  logic [WIDTH-1:0] res_q;
  logic [4:0]       flg_q;
  logic             legal_q;
  logic             legal_d;
  logic             is_cmp;
  logic [WIDTH-1:0] src_d;
  logic [3:0]       op, ext;

  assign op     = ir[15:12];
  assign ext    = ir[7:4];
  assign is_cmp = ((op == 4'b0000) && (ext == 4'b1011)) || (op == 4'b1011);

  always_comb begin
    legal_d = 1'b0;
    case (op)
      4'b0000: begin
        case (ext)
          4'b0101, 4'b0110, 4'b0111, 4'b1110, 4'b1001, 4'b1010,
          4'b1011, 4'b0001, 4'b0010, 4'b0011, 4'b1101: legal_d = 1'b1;
          default: legal_d = 1'b0;
        endcase
      end
      4'b1000: begin
        case (ext)
          4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0110: legal_d = 1'b1;
          default: legal_d = 1'b0;
        endcase
      end
      4'b0101, 4'b0110, 4'b1001, 4'b1011, 4'b0001,
      4'b0010, 4'b0011, 4'b1101, 4'b1111: legal_d = 1'b1;
      default: legal_d = 1'b0;
    endcase
  end

  // Shifts by register take Rsrc data; shifts by constant use the 4-bit field as the amount.
  always_comb begin
    src_d = '0;
    case (op)
      4'b0000: src_d = rf_rdata_a;
      4'b1000: begin
        if ((ext == 4'b0100) || (ext == 4'b0110)) src_d = rf_rdata_a;
        else                                      src_d = {{(WIDTH-4){1'b0}}, ir[3:0]};
      end
      4'b0101, 4'b1001, 4'b1011:                   src_d = {{(WIDTH-8){ir[7]}}, ir[7:0]};
      4'b0110, 4'b0001, 4'b0010, 4'b0011,
      4'b1101, 4'b1111:                            src_d = {{(WIDTH-8){1'b0}}, ir[7:0]};
      default:                                     src_d = '0;
    endcase
  end

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    rf_raddr_a  = '0;
    rf_raddr_b  = '0;
    alu_en      = 1'b0;
    alu_op      = '0;
    alu_src     = '0;
    alu_dst     = '0;
    rf_we       = 1'b0;
    rf_waddr    = '0;
    rf_wdata    = '0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nxt = READ;
      end
      READ: begin
        rf_raddr_a = ir[3:0];
        rf_raddr_b = ir[11:8];
        state_nxt  = EXEC;
      end
      EXEC: begin
        alu_en    = 1'b1;
        alu_op    = {ir[15:12], ir[7:4]};
        alu_dst   = rf_rdata_b;
        alu_src   = src_d;
        state_nxt = WB;
      end
      WB: begin
        done    = 1'b1;
        illegal = ~legal_q;
        if (legal_q && !is_cmp) begin
          rf_we    = 1'b1;
          rf_waddr = ir[11:8];
          rf_wdata = res_q;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ir      <= '0;
      res_q   <= '0;
      flg_q   <= '0;
      legal_q <= 1'b0;
      psr     <= '0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && instr_valid) ir <= instr;
      if (state == READ) legal_q <= legal_d;
      if (state == EXEC) begin
        res_q <= alu_result;
        flg_q <= alu_flags;
      end
      if ((state == WB) && legal_q) psr <= flg_q;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized bench for alu_sequencer: behavioural register file, ALU and instruction-level reference model.
module tb_alu_sequencer;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         instr_valid;
  logic [15:0]  instr;
  logic         instr_ready;
  logic [3:0]   rf_raddr_a, rf_raddr_b;
  logic [W-1:0] rf_rdata_a, rf_rdata_b;
  logic [W-1:0] alu_src, alu_dst;
  logic [7:0]   alu_op;
  logic         alu_en;
  logic [W-1:0] alu_result;
  logic [4:0]   alu_flags;
  logic         rf_we;
  logic [3:0]   rf_waddr;
  logic [W-1:0] rf_wdata;
  logic [4:0]   psr;
  logic         done;
  logic         illegal;

  always #5 clk = ~clk;

  alu_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b), .alu_src(alu_src),
    .alu_dst(alu_dst), .alu_op(alu_op), .alu_en(alu_en), .alu_result(alu_result),
    .alu_flags(alu_flags), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .psr(psr), .done(done), .illegal(illegal)
  );

  // Register file: synchronous read, written by the DUT or by bench preloads.
  logic [W-1:0] rf_mem [16];
  logic         pre_we = 1'b0;
  logic [3:0]   pre_addr = '0;
  logic [W-1:0] pre_dat = '0;
  int           cyc = 0;

  always @(posedge clk) begin
    if (pre_we)     rf_mem[pre_addr] <= pre_dat;
    else if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
    rf_rdata_a <= rf_mem[rf_raddr_a];
    rf_rdata_b <= rf_mem[rf_raddr_b];
    cyc <= cyc + 1;
  end

  function automatic logic [W+4:0] alu_f(input logic [7:0] op, input logic [W-1:0] s,
                                         input logic [W-1:0] d);
    logic [W:0]   sum;
    logic [W-1:0] r;
    logic [4:0]   f;
    if ((op == 8'h05) || (op[7:4] == 4'h5)) begin
      sum = {1'b0, d} + {1'b0, s};
      r   = sum[W-1:0];
      f   = {sum[W], 1'b0, (d[W-1] == s[W-1]) && (r[W-1] != d[W-1]), r == 0, r[W-1]};
    end else if ((op == 8'h09) || (op == 8'h0B) || (op[7:4] == 4'h9) || (op[7:4] == 4'hB)) begin
      r = d - s;
      f = {d >= s, d < s, (d[W-1] != s[W-1]) && (r[W-1] != d[W-1]), r == 0, $signed(d) < $signed(s)};
    end else begin
      r = (d << 1) ^ s ^ W'(op);
      f = {r[0], r[1], r[2], r == 0, r[W-1]};
    end
    return {f, r};
  endfunction

  always_comb {alu_flags, alu_result} = alu_f(alu_op, alu_src, alu_dst);

  // Reference model state and decode tables.
  logic [W-1:0] ref_rf [16];
  logic [4:0]   ref_psr = '0;
  logic [3:0]   legal_ops [11] = '{4'h0, 4'h8, 4'h5, 4'h6, 4'h9, 4'hB, 4'h1, 4'h2, 4'h3, 4'hD, 4'hF};
  logic [3:0]   op0_ext   [11] = '{4'h5, 4'h6, 4'h7, 4'hE, 4'h9, 4'hA, 4'hB, 4'h1, 4'h2, 4'h3, 4'hD};
  logic [3:0]   op8_ext   [6]  = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6};
  int           n_chk = 0;
  int           n_pass = 0;
  int           done_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic bit ref_legal(input logic [15:0] i);
    bit ok = 1'b0;
    if (i[15:12] == 4'h0) begin
      foreach (op0_ext[k]) if (op0_ext[k] == i[7:4]) ok = 1'b1;
    end else if (i[15:12] == 4'h8) begin
      foreach (op8_ext[k]) if (op8_ext[k] == i[7:4]) ok = 1'b1;
    end else begin
      foreach (legal_ops[k]) if (legal_ops[k] == i[15:12]) ok = 1'b1;
    end
    return ok;
  endfunction

  function automatic logic [W-1:0] ref_src(input logic [15:0] i, input logic [W-1:0] ra);
    logic signed [7:0] simm;
    simm = i[7:0];
    if (i[15:12] == 4'h0) return ra;
    if (i[15:12] == 4'h8) return ((i[7:4] == 4'h4) || (i[7:4] == 4'h6)) ? ra : W'(i[3:0]);
    if ((i[15:12] == 4'h5) || (i[15:12] == 4'h9) || (i[15:12] == 4'hB)) return W'(simm);
    return W'(i[7:0]);
  endfunction

  function automatic bit is_compare(input logic [15:0] i);
    return ((i[15:12] == 4'h0) && (i[7:4] == 4'hB)) || (i[15:12] == 4'hB);
  endfunction

  function automatic logic [15:0] gen();
    logic [15:0] i;
    i = 16'($urandom);
    if ($urandom_range(0, 9) < 7) begin
      i[15:12] = legal_ops[$urandom_range(0, 10)];
      if (i[15:12] == 4'h0)      i[7:4] = op0_ext[$urandom_range(0, 10)];
      else if (i[15:12] == 4'h8) i[7:4] = op8_ext[$urandom_range(0, 5)];
    end
    return i;
  endfunction

  task automatic preload(input logic [3:0] a, input logic [W-1:0] v);
    pre_we = 1'b1; pre_addr = a; pre_dat = v;
    ref_rf[a] = v;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Entered and left at a falling edge with the DUT idle.
  task automatic run(input logic [15:0] ins, input bit keep, input logic [15:0] nxt);
    logic [3:0]   rd, rs;
    logic         lg, we;
    logic [W-1:0] s, d, r;
    logic [4:0]   f;
    logic [W+4:0] af;
    rd = ins[11:8];
    rs = ins[3:0];
    lg = ref_legal(ins);
    we = lg && !is_compare(ins);
    s  = ref_src(ins, ref_rf[rs]);
    d  = ref_rf[rd];
    af = alu_f({ins[15:12], ins[7:4]}, s, d);
    r  = af[W-1:0];
    f  = af[W+4:W];
    chk("idle_ready", instr_ready, 1);
    instr_valid = 1'b1;
    instr = ins;
    @(negedge clk);
    if (keep) instr = nxt;
    else instr_valid = 1'b0;
    chk("read_ready", instr_ready, 0);
    chk("read_raddr_a", rf_raddr_a, rs);
    chk("read_raddr_b", rf_raddr_b, rd);
    chk("read_alu_en", alu_en, 0);
    chk("read_done", done, 0);
    @(negedge clk);
    chk("exec_alu_en", alu_en, 1);
    chk("exec_alu_op", alu_op, {ins[15:12], ins[7:4]});
    chk("exec_alu_dst", alu_dst, d);
    if (lg) chk("exec_alu_src", alu_src, s);
    chk("exec_raddr_a", rf_raddr_a, 0);
    chk("exec_done", done, 0);
    @(negedge clk);
    chk("wb_done", done, 1);
    chk("wb_illegal", illegal, !lg);
    chk("wb_rf_we", rf_we, we);
    if (we) begin
      chk("wb_waddr", rf_waddr, rd);
      chk("wb_wdata", rf_wdata, r);
    end
    chk("wb_alu_en", alu_en, 0);
    chk("wb_ready", instr_ready, 0);
    done_cyc = cyc;
    if (lg) ref_psr = f;
    if (we) ref_rf[rd] = r;
    @(negedge clk);
    chk("post_psr", psr, ref_psr);
    chk("post_done", done, 0);
    chk("post_rf_we", rf_we, 0);
  endtask

  initial begin
    logic [15:0] cur, nxt;
    logic [4:0]  p;
    int          t1;
    bit          keep;
    reset = 1'b1; instr_valid = 1'b0; instr = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", instr_ready, 1);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_done", done, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_alu_en", alu_en, 0);
    chk("rst_psr", psr, 0);
    for (int k = 0; k < 16; k++) preload(k[3:0], W'($urandom));

    preload(4'd1, 16'h0003); preload(4'd2, 16'h0005);
    run(16'h0251, 1'b0, 16'h0);
    chk("add_r2", rf_mem[2], 16'h0008);
    preload(4'd3, 16'h0001);
    run(16'h53FF, 1'b0, 16'h0);
    chk("addi_r3", rf_mem[3], 16'h0000);
    chk("addi_carry", psr[4], 1);
    preload(4'd4, 16'h0003);
    run(16'hB405, 1'b0, 16'h0);
    chk("cmpi_r4", rf_mem[4], 16'h0003);
    chk("cmpi_low", psr[3], 1);
    chk("cmpi_neg", psr[0], 1);
    p = psr;
    run(16'h4000, 1'b0, 16'h0);
    chk("illegal_psr", psr, p);

    // Reset during EXEC aborts the instruction.
    preload(4'd1, 16'h0003); preload(4'd2, 16'h0005);
    instr_valid = 1'b1; instr = 16'h0251;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("abort_exec_en", alu_en, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ref_psr = '0;
    chk("abort_ready", instr_ready, 1);
    chk("abort_done", done, 0);
    chk("abort_rf_we", rf_we, 0);
    chk("abort_psr", psr, 0);
    chk("abort_alu_en", alu_en, 0);
    chk("abort_r2", rf_mem[2], 16'h0005);

    // Offer coinciding with reset is dropped.
    reset = 1'b1; instr_valid = 1'b1; instr = 16'h0251;
    @(negedge clk);
    reset = 1'b0; instr_valid = 1'b0;
    chk("rstvld_ready", instr_ready, 1);
    chk("rstvld_raddr_b", rf_raddr_b, 0);
    repeat (3) begin
      @(negedge clk);
      chk("rstvld_done", done, 0);
    end

    // Held valid: second instruction follows the first done by one idle cycle.
    run(16'h0251, 1'b1, 16'h5112);
    t1 = done_cyc;
    run(16'h5112, 1'b0, 16'h0);
    chk("b2b_gap", done_cyc - t1, 4);

    cur = gen();
    for (int n = 0; n < 200; n++) begin
      keep = ($urandom_range(0, 3) == 0);
      nxt = gen();
      run(cur, keep, nxt);
      cur = nxt;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
